t48_pmem_fetch: RTL
===================

# t48_pmem_fetch

Program-memory fetch engine between the T48 program-memory controller's 12-bit fetch address and the actual storage. Each accepted fetch request is served either from the on-chip ROM or through an 8048-style external bus cycle (ALE / PSEN_n, multiplexed DB, upper address on P2[3:0]). The fetched byte is returned with a one-cycle valid strobe, which the controller uses as its program-memory read data.

## Interface
Parameters:
- ROM_SIZE_LOG2, 10, log2 of internal ROM bytes; addresses at or above 2^ROM_SIZE_LOG2 go external.
- PSEN_WAIT, 1, number of enabled cycles PSEN_n stays low before DB is sampled (1..15).

Ports:
- clk_i  in  1  system clock; one clock domain.
- res_i  in  1  reset, asynchronous, active-high.
- en_clk_i  in  1  clock enable; the FSM, counter and captures advance only when high.
- req_i  in  1  fetch request; accepted only in IDLE with en_clk_i=1.
- addr_i  in  12  fetch address; sampled on acceptance.
- ea_i  in  1  external-access force; sampled on acceptance.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- valid_o  out  1  one-clk pulse; data_o is updated in the same cycle.
- data_o  out  8  last fetched byte; holds until the next capture.
- rom_addr_o  out  12  internal ROM address, equal to the latched address.
- rom_data_i  in  8  synchronous ROM output, one clk latency.
- ale_o  out  1  address latch enable.
- psen_n_o  out  1  program store enable, active low.
- db_o  out  8  DB drive value.
- db_dir_o  out  1  1 = drive DB, 0 = release DB.
- db_i  in  8  DB input.
- p2_addr_o  out  4  upper address nibble for P2[3:0].

## Operation
- Latched registers: addr_q[11:0], ext_q.
- On acceptance (IDLE, en_clk_i=1, req_i=1):
  - addr_q is loaded from addr_i.
  - ext_q is set to ea_i OR (addr_i >> ROM_SIZE_LOG2) != 0.
  - The next state is INT_RD if ext_q=0, otherwise EXT_ALE.
- INT_RD:
  - rom_addr_o = addr_q.
  - On the next enabled clk: data_o <= rom_data_i, valid_o pulses, go to IDLE.
- EXT_ALE:
  - ale_o=1, db_dir_o=1, db_o=addr_q[7:0].
  - p2_addr_o is loaded with addr_q[11:8] on entry.
  - Go to EXT_ADDR.
- EXT_ADDR:
  - ale_o=0; DB is still driven with addr_q[7:0] (hold time).
  - The wait counter loads PSEN_WAIT-1.
  - Go to EXT_PSEN.
- EXT_PSEN:
  - db_dir_o=0, psen_n_o=0.
  - On each enabled clk: if the counter is 0, data_o <= db_i, valid_o pulses, go to IDLE; otherwise decrement the counter.
- Held values:
  - p2_addr_o keeps its value after the cycle completes, until the next external fetch.
  - rom_addr_o tracks addr_q at all times.
- Outside the states above: ale_o=0, psen_n_o=1, db_dir_o=0, db_o=0.
- Requests while busy_o=1 are ignored; they are not queued. A request in the same clk as valid_o is accepted, because the FSM is already in IDLE.
- en_clk_i=0 freezes the state, counter and all registered outputs. valid_o is still a single-clk pulse and is never stretched.
- Reset, including mid-cycle, immediately forces:
  - state=IDLE; addr_q, counter, data_o, rom_addr_o, db_o, p2_addr_o = 0;
  - valid_o, busy_o, ale_o, db_dir_o = 0;
  - psen_n_o = 1;
  - no partial cycle resumes after reset.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from db_i or rom_data_i to outputs.
- Internal fetch latency, counted in enabled clks from acceptance to valid_o: 2.
- External fetch latency: 3 + PSEN_WAIT enabled clks.
  - ALE is high for 1 enabled clk.
  - Address hold is 1 enabled clk.
  - PSEN_n is low for PSEN_WAIT enabled clks.
  - DB is sampled on the last PSEN-low edge.
  - psen_n_o returns to 1 in the same clk that valid_o rises.
- ROM contract: rom_data_i must be valid for rom_addr_o one clk after rom_addr_o changes.
- Address boundary: addr 2^ROM_SIZE_LOG2-1 is internal; 2^ROM_SIZE_LOG2 is external. 0xFFF is external unless ROM_SIZE_LOG2=12.

## Test plan
- Internal fetch, en_clk_i=1, ea_i=0, addr_i=0x123, ROM returns 0xA5:
  - rom_addr_o=0x123.
  - valid_o and data_o=0xA5 exactly 2 clks after acceptance.
  - ale_o stays 0 and psen_n_o stays 1 throughout.
- External fetch, addr_i=0x5A3, PSEN_WAIT=1, db_i=0x3C during PSEN:
  - ALE clk shows db_o=0xA3, db_dir_o=1, p2_addr_o=0x5.
  - Next clk shows ale_o=0 with DB still driven.
  - Next clk shows psen_n_o=0 and db_dir_o=0.
  - Next clk shows valid_o=1 and data_o=0x3C.
- ea_i=1 with addr_i=0x010, PSEN_WAIT=3:
  - The fetch takes the external path.
  - psen_n_o is low for 3 clks; latency is 6.
  - p2_addr_o=0x0.
- Busy and back-to-back requests:
  - req_i held high during an external fetch is ignored; busy_o=1 until completion.
  - A request in the valid_o clk starts the next fetch immediately.
  - Boundary: 0x3FF is internal and 0x400 is external with ROM_SIZE_LOG2=10.
- en_clk_i stalls: en_clk_i alternating 1/0 during an internal and an external fetch:
  - Latency counts only enabled clks.
  - Outputs are frozen in disabled clks.
  - valid_o stays 1 clk wide.
- Reset during EXT_PSEN:
  - All outputs are at reset values in the same cycle (psen_n_o=1, db_dir_o=0, busy_o=0).
  - A fresh request after reset release completes normally.

Source files
------------

// File: rtl/t48_pmem_fetch.sv
// t48_pmem_fetch
// Program-memory fetch engine for the T48 core. It serves each accepted fetch
// from the on-chip ROM or through an 8048-style external bus cycle
// (ALE, then address hold, then PSEN_n low).
// The fetched byte is returned with a one-clk valid strobe.
module t48_pmem_fetch #(
   parameter int ROM_SIZE_LOG2 = 10,
   parameter int PSEN_WAIT     = 1
) (
   input  logic        clk_i,
   input  logic        res_i,
   input  logic        en_clk_i,
   input  logic        req_i,
   input  logic [11:0] addr_i,
   input  logic        ea_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [7:0]  data_o,
   output logic [11:0] rom_addr_o,
   input  logic [7:0]  rom_data_i,
   output logic        ale_o,
   output logic        psen_n_o,
   output logic [7:0]  db_o,
   output logic        db_dir_o,
   input  logic [7:0]  db_i,
   output logic [3:0]  p2_addr_o
);

   typedef enum logic [2:0] {
      IDLE,
      INT_RD,
      EXT_ALE,
      EXT_ADDR,
      EXT_PSEN
   } state_t;

   // Reload value for the PSEN wait counter. The last PSEN-low clk is the one with count 0.
   localparam logic [3:0] WAIT_LOAD = 4'(PSEN_WAIT - 1);

   state_t      state_q;
   state_t      state_d;
   logic [11:0] addr_q;
   logic [3:0]  wait_cnt_q;
   logic        ext_sel;
   logic        accept;
   logic        done;

   // A fetch goes external when forced by EA, or when the address lies above the internal ROM.
   assign ext_sel    = ea_i | ((addr_i >> ROM_SIZE_LOG2) != 12'd0);
   assign accept     = en_clk_i & req_i & (state_q == IDLE);
   assign busy_o     = (state_q != IDLE);
   assign rom_addr_o = addr_q;

   // State register; the clock enable is applied in the next-state logic
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; done flags the enabled clk that completes a fetch
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      if (en_clk_i) begin
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  state_d = ext_sel ? EXT_ALE : INT_RD;
               end
            end
            INT_RD: begin
               state_d = IDLE;
               done    = 1'b1;
            end
            EXT_ALE: begin
               state_d = EXT_ADDR;
            end
            EXT_ADDR: begin
               state_d = EXT_PSEN;
            end
            EXT_PSEN: begin
               if (wait_cnt_q == 4'd0) begin
                  state_d = IDLE;
                  done    = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // External bus strobes and DB drive, decoded purely from registered state
   always_comb begin
      ale_o    = 1'b0;
      psen_n_o = 1'b1;
      db_dir_o = 1'b0;
      db_o     = 8'h00;
      case (state_q)
         EXT_ALE: begin
            ale_o    = 1'b1;
            db_dir_o = 1'b1;
            db_o     = addr_q[7:0];
         end
         EXT_ADDR: begin
            db_dir_o = 1'b1;
            db_o     = addr_q[7:0];
         end
         EXT_PSEN: begin
            psen_n_o = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Address latch, upper-address port (held between external fetches) and PSEN wait counter
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         addr_q     <= 12'h000;
         p2_addr_o  <= 4'h0;
         wait_cnt_q <= 4'd0;
      end else if (en_clk_i) begin
         if (accept) begin
            addr_q <= addr_i;
            if (ext_sel) begin
               p2_addr_o <= addr_i[11:8];
            end
         end
         if (state_q == EXT_ADDR) begin
            wait_cnt_q <= WAIT_LOAD;
         end else if ((state_q == EXT_PSEN) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
         end
      end
   end

   // Read-data capture; valid is cleared every clk, so it never stretches across disabled clks
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         valid_o <= 1'b0;
         data_o  <= 8'h00;
      end else begin
         valid_o <= done;
         if (done) begin
            data_o <= (state_q == INT_RD) ? rom_data_i : db_i;
         end
      end
   end

endmodule
